// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, iterative shift-add multiplier
// and the EX/MEM pipeline register feeding the memory stage.
module ex_stage #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] imm,
    input  logic [4:0]  rs_idx,
    input  logic [4:0]  rt_idx,
    input  logic [4:0]  rd_idx,
    input  logic [4:0]  shamt,
    input  logic        regdst,
    input  logic [3:0]  aluop,
    input  logic [1:0]  alusrca,
    input  logic [1:0]  alusrcb,
    input  logic        mem2reg,
    input  logic        regwr,
    input  logic        memwr,
    input  logic        flush,
    input  logic        wb_regwr,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_data,
    output logic        stall_req,
    output logic [31:0] exm_alu,
    output logic [31:0] exm_store,
    output logic [4:0]  exm_dst,
    output logic        exm_mem2reg,
    output logic        exm_regwr,
    output logic        exm_memwr
);

    localparam int unsigned CW = $clog2(MUL_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11,
        OP_MUL  = 4'd12
    } op_t;

    state_t state, state_next;

    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res;
    logic [31:0] mcand, mplier, acc, acc_next;
    logic [CW-1:0] cnt;
    logic        last;
    logic        mul_start, load_alu, load_mul;

    logic [31:0] hold_store;
    logic [4:0]  hold_dst;
    logic        hold_m2r, hold_rw, hold_mw;

    // EX/MEM result has priority over MEM/WB; register 0 is never forwarded
    always_comb begin
        if (exm_regwr && exm_dst != 5'd0 && exm_dst == rs_idx)
            fwd_a = exm_alu;
        else if (wb_regwr && wb_dst != 5'd0 && wb_dst == rs_idx)
            fwd_a = wb_data;
        else
            fwd_a = rs_val;

        if (exm_regwr && exm_dst != 5'd0 && exm_dst == rt_idx)
            fwd_b = exm_alu;
        else if (wb_regwr && wb_dst != 5'd0 && wb_dst == rt_idx)
            fwd_b = wb_data;
        else
            fwd_b = rt_val;
    end

    always_comb begin
        case (alusrca)
            2'd0:    op_a = fwd_a;
            2'd1:    op_a = {27'b0, shamt};
            default: op_a = '0;
        endcase
        case (alusrcb)
            2'd0:    op_b = fwd_b;
            2'd1:    op_b = imm;
            default: op_b = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (aluop)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {31'b0, op_a < op_b};
            OP_SLL:  alu_res = op_b << op_a[4:0];
            OP_SRL:  alu_res = op_b >> op_a[4:0];
            OP_SRA:  alu_res = $signed(op_b) >>> op_a[4:0];
            OP_LUI:  alu_res = {op_b[15:0], 16'b0};
            default: alu_res = '0;
        endcase
    end

    assign last      = (cnt == CW'(MUL_CYCLES - 1));
    assign acc_next  = acc + (mplier[0] ? mcand : '0);
    assign mul_start = (state == IDLE) && !flush && (aluop == OP_MUL);
    assign load_alu  = (state == IDLE) && !flush && (aluop != OP_MUL);
    assign load_mul  = (state == BUSY) && !flush && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mul_start) state_next = BUSY;
            BUSY: if (flush || last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset gates the request so the upstream hold drops before any edge
    always_comb begin
        stall_req = 1'b0;
        if (!rst && !flush) begin
            case (state)
                IDLE:    stall_req = (aluop == OP_MUL);
                BUSY:    stall_req = !last;
                default: stall_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            hold_store <= '0;
            hold_dst   <= '0;
            hold_m2r   <= 1'b0;
            hold_rw    <= 1'b0;
            hold_mw    <= 1'b0;
        end else if (mul_start) begin
            mcand      <= op_a;
            mplier     <= op_b;
            acc        <= '0;
            cnt        <= '0;
            hold_store <= fwd_b;
            hold_dst   <= regdst ? rd_idx : rt_idx;
            hold_m2r   <= mem2reg;
            hold_rw    <= regwr;
            hold_mw    <= memwr;
        end else if (state == BUSY) begin
            if (flush) begin
                cnt <= '0;
            end else begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exm_alu     <= '0;
            exm_store   <= '0;
            exm_dst     <= '0;
            exm_mem2reg <= 1'b0;
            exm_regwr   <= 1'b0;
            exm_memwr   <= 1'b0;
        end else if (load_alu) begin
            exm_alu     <= alu_res;
            exm_store   <= fwd_b;
            exm_dst     <= regdst ? rd_idx : rt_idx;
            exm_mem2reg <= mem2reg;
            exm_regwr   <= regwr;
            exm_memwr   <= memwr;
        end else if (load_mul) begin
            exm_alu     <= acc_next;
            exm_store   <= hold_store;
            exm_dst     <= hold_dst;
            exm_mem2reg <= hold_m2r;
            exm_regwr   <= hold_rw;
            exm_memwr   <= hold_mw;
        end else begin
            exm_alu     <= '0;
            exm_store   <= '0;
            exm_dst     <= '0;
            exm_mem2reg <= 1'b0;
            exm_regwr   <= 1'b0;
            exm_memwr   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ALU
// traffic against a behavioural model of the EX/MEM register contents.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs_val, rt_val, imm, wb_data;
    logic [4:0]  rs_idx, rt_idx, rd_idx, shamt, wb_dst;
    logic        regdst, mem2reg, regwr, memwr, flush, wb_regwr;
    logic [3:0]  aluop;
    logic [1:0]  alusrca, alusrcb;
    logic        stall_req;
    logic [31:0] exm_alu, exm_store;
    logic [4:0]  exm_dst;
    logic        exm_mem2reg, exm_regwr, exm_memwr;

    ex_stage #(.MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx), .shamt(shamt),
        .regdst(regdst), .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb),
        .mem2reg(mem2reg), .regwr(regwr), .memwr(memwr), .flush(flush),
        .wb_regwr(wb_regwr), .wb_dst(wb_dst), .wb_data(wb_data),
        .stall_req(stall_req),
        .exm_alu(exm_alu), .exm_store(exm_store), .exm_dst(exm_dst),
        .exm_mem2reg(exm_mem2reg), .exm_regwr(exm_regwr), .exm_memwr(exm_memwr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected EX/MEM contents
    logic [31:0] e_alu, e_store;
    logic [4:0]  e_dst;
    logic        e_m2r, e_rw, e_mw;

    logic [74:0] obs;
    assign obs = {exm_alu, exm_store, exm_dst, exm_mem2reg, exm_regwr, exm_memwr};

    function automatic logic [74:0] expv();
        return {e_alu, e_store, e_dst, e_m2r, e_rw, e_mw};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_bubble();
        e_alu = '0; e_store = '0; e_dst = '0;
        e_m2r = 1'b0; e_rw = 1'b0; e_mw = 1'b0;
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] val);
        if (e_rw && e_dst != 0 && e_dst == idx) return e_alu;
        if (wb_regwr && wb_dst != 0 && wb_dst == idx) return wb_data;
        return val;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [63:0] prod;
        sa = a; sb = b;
        prod = 64'(a) * 64'(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << a[4:0];
            4'd9:  return b >> a[4:0];
            4'd10: return 32'(sb >>> a[4:0]);
            4'd11: return {b[15:0], 16'h0000};
            4'd12: return prod[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_ops(output logic [31:0] a, output logic [31:0] b, output logic [31:0] fb);
        logic [31:0] fa;
        fa = ref_fwd(rs_idx, rs_val);
        fb = ref_fwd(rt_idx, rt_val);
        a = (alusrca == 2'd0) ? fa : (alusrca == 2'd1) ? {27'b0, shamt} : 32'd0;
        b = (alusrcb == 2'd0) ? fb : (alusrcb == 2'd1) ? imm : 32'd0;
    endtask

    // Next EX/MEM contents for a single-cycle op presented in IDLE
    task automatic model_edge();
        logic [31:0] a, b, fb;
        ref_ops(a, b, fb);
        if (flush || aluop == 4'd12) begin
            model_bubble();
        end else begin
            e_alu = ref_alu(aluop, a, b);
            e_store = fb;
            e_dst = regdst ? rd_idx : rt_idx;
            e_m2r = mem2reg; e_rw = regwr; e_mw = memwr;
        end
    endtask

    task automatic set_idle_inputs();
        rs_val = '0; rt_val = '0; imm = '0; rs_idx = '0; rt_idx = '0; rd_idx = '0;
        shamt = '0; regdst = 1'b0; aluop = 4'd0; alusrca = 2'd0; alusrcb = 2'd0;
        mem2reg = 1'b0; regwr = 1'b0; memwr = 1'b0; flush = 1'b0;
        wb_regwr = 1'b0; wb_dst = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        set_idle_inputs();
        aluop = 4'd12;
        rst = 1'b1;
        #2;
        model_bubble();
        if (obs !== expv()) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, expv()); end
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        checks++;
        aluop = 4'd0;
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        set_idle_inputs();
        rs_val = 32'd5; imm = 32'hFFFF_FFFF; alusrcb = 2'd1; regwr = 1'b1; rt_idx = 5'd9;
        rs_idx = 5'd20; rd_idx = 5'd17;
        model_edge();
        tick();
        if (obs !== expv() || exm_alu !== 32'd4 || exm_dst !== 5'd9 || exm_regwr !== 1'b1) begin
            errors++; $display("FAIL add_basic: got %h expected %h", obs, expv());
        end
        checks++;
    endtask

    task automatic test_forward();
        set_idle_inputs();
        rs_val = 32'h10; alusrcb = 2'd1; regwr = 1'b1; regdst = 1'b1; rd_idx = 5'd3; rs_idx = 5'd12;
        model_edge();
        tick();
        if (obs !== expv()) begin errors++; $display("FAIL fwd_setup: got %h expected %h", obs, expv()); end
        checks++;
        rs_idx = 5'd3; rs_val = 32'hDEAD; imm = 32'd1; rd_idx = 5'd4;
        wb_regwr = 1'b1; wb_dst = 5'd3; wb_data = 32'h20;
        model_edge();
        tick();
        if (exm_alu !== 32'h11 || obs !== expv()) begin
            errors++; $display("FAIL fwd_priority: got %h expected %h", obs, expv());
        end
        checks++;
        rd_idx = 5'd0; rs_idx = 5'd6; rs_val = 32'h77;
        model_edge();
        tick();
        rs_idx = 5'd0; rs_val = 32'h55; wb_dst = 5'd0; wb_data = 32'h99; rd_idx = 5'd2;
        model_edge();
        tick();
        if (exm_alu !== 32'h56 || obs !== expv()) begin
            errors++; $display("FAIL fwd_reg0: got %h expected %h", obs, expv());
        end
        checks++;
    endtask

    task automatic test_shift_slt();
        set_idle_inputs();
        aluop = 4'd10; alusrca = 2'd1; shamt = 5'd4; alusrcb = 2'd1; imm = 32'h8000_0000;
        regwr = 1'b1; rt_idx = 5'd8;
        model_edge();
        tick();
        if (exm_alu !== 32'hF800_0000 || obs !== expv()) begin
            errors++; $display("FAIL sra: got %h expected %h", obs, expv());
        end
        checks++;
        aluop = 4'd6; alusrca = 2'd0; rs_idx = 5'd20; rs_val = 32'hFFFF_FFFF; imm = 32'd1;
        model_edge();
        tick();
        if (exm_alu !== 32'd1 || obs !== expv()) begin
            errors++; $display("FAIL slt_signed: got %h expected %h", obs, expv());
        end
        checks++;
        aluop = 4'd7;
        model_edge();
        tick();
        if (exm_alu !== 32'd0 || obs !== expv()) begin
            errors++; $display("FAIL sltu: got %h expected %h", obs, expv());
        end
        checks++;
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            rs_val = $urandom; rt_val = $urandom; imm = $urandom; wb_data = $urandom;
            rs_idx = 5'($urandom_range(0, 3)); rt_idx = 5'($urandom_range(0, 3));
            rd_idx = 5'($urandom_range(0, 3)); wb_dst = 5'($urandom_range(0, 3));
            shamt = 5'($urandom); regdst = 1'($urandom); wb_regwr = 1'($urandom);
            alusrca = 2'($urandom); alusrcb = 2'($urandom);
            mem2reg = 1'($urandom); regwr = 1'($urandom); memwr = 1'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            aluop = 4'($urandom_range(0, 15));
            if (aluop == 4'd12 && !flush) aluop = 4'd0;
            #1;
            if (stall_req !== 1'b0) begin errors++; $display("FAIL rand_stall[%0d]: got %b expected 0", i, stall_req); end
            checks++;
            model_edge();
            tick();
            if (obs !== expv()) begin
                errors++; $display("FAIL rand_op[%0d] op=%0d: got %h expected %h", i, aluop, obs, expv());
            end
            checks++;
        end
        flush = 1'b0;
    endtask

    task automatic run_mul(input logic [31:0] a_in, input logic [31:0] b_in, input string name);
        logic [31:0] a, b, fb, prod;
        logic [4:0]  dst;
        bit done;
        set_idle_inputs();
        aluop = 4'd12; rs_val = a_in; rt_val = b_in; rs_idx = 5'd21; rt_idx = 5'd22;
        regdst = 1'b1; rd_idx = 5'd7; regwr = 1'b1;
        ref_ops(a, b, fb);
        prod = ref_alu(4'd12, a, b);
        dst = rd_idx;
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (c == 3) begin wb_regwr = 1'b1; wb_dst = rs_idx; wb_data = 32'h0BAD_F00D; end
            #1;
            if (stall_req !== (c <= 32)) begin
                errors++; $display("FAIL %s_stall[%0d]: got %b expected %b", name, c, stall_req, c <= 32);
            end
            checks++;
            tick();
            if (c < 33) begin
                if (exm_regwr !== 1'b0 || obs !== 75'd0) begin
                    errors++; $display("FAIL %s_bubble[%0d]: got %h expected 0", name, c, obs);
                end
                checks++;
            end else begin
                e_alu = prod; e_store = fb; e_dst = dst; e_m2r = 1'b0; e_rw = 1'b1; e_mw = 1'b0;
                if (obs !== expv()) begin
                    errors++; $display("FAIL %s_result: got %h expected %h", name, obs, expv());
                end
                checks++;
                done = 1'b1;
            end
        end
        if (!done) begin errors++; $display("FAIL %s_timeout: no result expected by edge 33", name); checks++; end
    endtask

    task automatic test_mul();
        run_mul(32'h1234_5678, 32'h9ABC_DEF0, "mul_dir");
        set_idle_inputs();
        aluop = 4'd0; rs_idx = 5'd7; imm = 32'd3; alusrcb = 2'd1; regwr = 1'b1; rt_idx = 5'd10;
        #1;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL mul_follow_stall: got %b expected 0", stall_req); end
        checks++;
        model_edge();
        tick();
        if (obs !== expv()) begin errors++; $display("FAIL mul_follow_add: got %h expected %h", obs, expv()); end
        checks++;
    endtask

    task automatic test_back_to_back();
        run_mul($urandom, $urandom, "mul_b2b0");
        run_mul($urandom, $urandom, "mul_b2b1");
    endtask

    task automatic test_mul_abort();
        set_idle_inputs();
        aluop = 4'd12; flush = 1'b1; rs_val = 32'd9; rt_val = 32'd9; regwr = 1'b1;
        #1;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_vs_start_stall: got %b expected 0", stall_req); end
        checks++;
        model_edge();
        tick();
        if (obs !== expv()) begin errors++; $display("FAIL flush_vs_start: got %h expected %h", obs, expv()); end
        checks++;
        flush = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
        flush = 1'b1;
        #1;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b expected 0", stall_req); end
        checks++;
        model_bubble();
        tick();
        if (exm_regwr !== 1'b0 || obs !== expv()) begin
            errors++; $display("FAIL abort_bubble: got %h expected %h", obs, expv());
        end
        checks++;
        flush = 1'b0; aluop = 4'd3; rs_val = 32'hF0; imm = 32'h0F; alusrcb = 2'd1; rt_idx = 5'd5;
        #1;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL abort_idle_stall: got %b expected 0", stall_req); end
        checks++;
        model_edge();
        tick();
        if (obs !== expv()) begin errors++; $display("FAIL abort_next_op: got %h expected %h", obs, expv()); end
        checks++;
    endtask

    task automatic test_reset_mid();
        set_idle_inputs();
        rs_val = 32'h40; imm = 32'h2; alusrcb = 2'd1; regwr = 1'b1; memwr = 1'b1; rt_idx = 5'd11;
        model_edge();
        tick();
        if (obs !== expv()) begin errors++; $display("FAIL rst_mid_setup: got %h expected %h", obs, expv()); end
        checks++;
        aluop = 4'd12;
        #1 rst = 1'b1;
        #1;
        model_bubble();
        if (obs !== expv() || stall_req !== 1'b0) begin
            errors++; $display("FAIL rst_async_idle: got %h stall %b expected %h stall 0", obs, stall_req, expv());
        end
        checks++;
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1;
        #1;
        if (obs !== expv() || stall_req !== 1'b0) begin
            errors++; $display("FAIL rst_async_busy: got %h stall %b expected %h stall 0", obs, stall_req, expv());
        end
        checks++;
        aluop = 4'd1; rs_val = 32'd100; imm = 32'd1;
        #1 rst = 1'b0;
        #1;
        if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_after_stall: got %b expected 0", stall_req); end
        checks++;
        model_edge();
        tick();
        if (obs !== expv()) begin errors++; $display("FAIL rst_after_op: got %h expected %h", obs, expv()); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_shift_slt();
        test_random(200);
        test_mul();
        test_back_to_back();
        test_mul_abort();
        test_random(50);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX pipeline register; consumes its outputs.
- Forwards rs/rt operands from EX/MEM and MEM/WB.
- Computes the ALU result; MUL runs on a multi-cycle shift-add unit that stalls upstream via stall_req.
- Owns the EX/MEM pipeline register and drives MEM-stage inputs directly.

Parameters:
- MUL_CYCLES, 32, shift-add iterations per MUL (fixed at 32 for 32-bit operands).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs_val  in  32  rs register value from ID/EX.
- rt_val  in  32  rt register value from ID/EX.
- imm  in  32  already-extended immediate from ID/EX.
- rs_idx  in  5  rs index.
- rt_idx  in  5  rt index.
- rd_idx  in  5  rd index.
- shamt  in  5  shift amount.
- regdst  in  1  1 = dest rd, 0 = dest rt.
- aluop  in  4  operation code.
- alusrca  in  2  A select.
- alusrcb  in  2  B select.
- mem2reg, regwr, memwr  in  1 each  control from ID/EX.
- flush  in  1  synchronous bubble insert.
- wb_regwr  in  1  MEM/WB write enable.
- wb_dst  in  5  MEM/WB destination.
- wb_data  in  32  MEM/WB write data.
- stall_req  out  1  hold PC, IF/ID and ID/EX this cycle.
- exm_alu  out  32  registered result.
- exm_store  out  32  registered forwarded rt (store data).
- exm_dst  out  5  registered destination.
- exm_mem2reg, exm_regwr, exm_memwr  out  1 each  registered control.

Behaviour:
- Reset (async): all exm_* = 0, FSM = IDLE, counter = 0, stall_req = 0.

Forwarding (combinational):
- fwdA = exm_alu if exm_regwr and exm_dst != 0 and exm_dst == rs_idx.
- Else wb_data if wb_regwr and wb_dst != 0 and wb_dst == rs_idx.
- Else rs_val.
- fwdB: same rules with rt_idx / rt_val.
- EX/MEM has priority over MEM/WB.
- Load-use is not resolved here; the upstream hazard unit stalls it.

Operand select:
- A: alusrca 0 = fwdA, 1 = {27'b0, shamt}, 2/3 = 0.
- B: alusrcb 0 = fwdB, 1 = imm, 2/3 = 0.

aluop encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR (all wrap mod 2^32, no overflow trap).
- 6 SLT (signed), 7 SLTU.
- 8 SLL, 9 SRL, 10 SRA: shift B by A[4:0].
- 11 LUI = {B[15:0], 16'b0}.
- 12 MUL = low 32 bits of A*B.
- 13-15 → result 0.

Destination: exm_dst = regdst ? rd_idx : rt_idx.

FSM, states IDLE / BUSY:
- IDLE, aluop != 12: every edge loads EX/MEM with computed values; stall_req = 0.
- IDLE, aluop == 12 and !flush:
  - stall_req = 1.
  - Edge: capture mcand = A, mplier = B, acc = 0, cnt = 0, → BUSY.
  - EX/MEM loads a bubble: regwr = memwr = mem2reg = 0, data/dst = 0.
- BUSY, each edge:
  - if mplier[0] then acc += mcand.
  - mcand <<= 1; mplier >>= 1; cnt++.
  - EX/MEM loads a bubble.
- stall_req = 1 in BUSY while cnt < 31.
- BUSY with cnt == 31: stall_req = 0; the edge loads EX/MEM with acc_next and the held controls, → IDLE.
- MUL timing: 32 stall cycles; result visible in exm_alu 33 edges after MUL entered EX.
- Operands are captured at MUL start; later MEM/WB changes do not affect the product.
- Forwarding during BUSY is irrelevant.

Flush:
- Next edge loads a bubble.
- In BUSY: abort, → IDLE, cnt = 0, stall_req = 0 that cycle.
- Flush has priority over MUL start.
- Reset mid-MUL: immediate IDLE, outputs 0.

Test Plan:
- Reset asserted mid-run → all exm_* = 0, stall_req = 0 asynchronously, before the next clk edge.
- ADD: rs_val = 5, imm = 0xFFFFFFFF, alusrcb = 1, regwr = 1, regdst = 0, rt_idx = 9 → next edge exm_alu = 4, exm_dst = 9, exm_regwr = 1.
- Forward priority: exm_regwr = 1, exm_dst = 3, exm_alu = 0x10; wb_regwr = 1, wb_dst = 3, wb_data = 0x20; rs_idx = 3, ADD with B = 1 → exm_alu = 0x11. Repeat with exm_dst = 0 and rs_idx = 0 → rs_val used.
- SRA: B = 0x80000000, shamt = 4, alusrca = 1 → exm_alu = 0xF8000000. SLT with -1 vs 1 → 1; SLTU → 0.
- MUL: A = 0x12345678, B = 0x9ABCDEF0 held by stall.
  - stall_req high exactly 32 cycles.
  - exm_regwr = 0 during those cycles.
  - On edge 33: exm_alu = 0x242D2080, exm_regwr = 1.
  - A following ADD enters EX on the next cycle.
- MUL aborted: flush on BUSY cycle 10 → stall_req low that cycle, exm_regwr = 0, FSM IDLE. Next non-MUL op completes in 1 cycle.
